// File: rtl/router_pkg.sv
// Shared header layout, buffer sizing and FSM encoding for the router packet source.
// Types and constants only; no timing or flow control lives here.
package router_pkg;

   localparam int DW        = 8;
   localparam int LEN_MSB   = 7;
   localparam int LEN_LSB   = 2;
   localparam int ADDR_MSB  = 1;
   localparam int ADDR_LSB  = 0;
   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int MAX_LEN   = 63;
   localparam int BUF_DEPTH = MAX_LEN + 1;
   localparam int BUF_AW    = $clog2(BUF_DEPTH);

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOAD     = 3'd1;
   localparam state_t ST_HEADER   = 3'd2;
   localparam state_t ST_PAYLOAD  = 3'd3;
   localparam state_t ST_PARITY   = 3'd4;
   localparam state_t ST_ERR_WAIT = 3'd5;
   localparam state_t ST_DONE     = 3'd6;

   function automatic logic [DW-1:0] make_hdr(input logic [5:0] len, input logic [1:0] addr);
      logic [DW-1:0] h;
      h                    = '0;
      h[LEN_MSB:LEN_LSB]   = len;
      h[ADDR_MSB:ADDR_LSB] = addr;
      return h;
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-bus signals of the packet source; master is the
// packet source itself, slave is whoever feeds requests and models the router.
interface router_pkt_tx_if;

   logic                     req_valid;
   logic                     req_ready;
   logic [1:0]               req_addr;
   logic [5:0]               req_len;
   logic [router_pkg::DW-1:0] pay_data;
   logic                     pay_valid;
   logic                     pay_ready;
   logic                     busy;
   logic                     err;
   logic [router_pkg::DW-1:0] data_out;
   logic                     pkt_vld;
   logic                     tx_active;
   logic                     done;
   logic                     done_err;
   logic                     done_inval;

   modport master (
      input  req_valid, req_addr, req_len, pay_data, pay_valid, busy, err,
      output req_ready, pay_ready, data_out, pkt_vld, tx_active, done, done_err, done_inval
   );

   modport slave (
      output req_valid, req_addr, req_len, pay_data, pay_valid, busy, err,
      input  req_ready, pay_ready, data_out, pkt_vld, tx_active, done, done_err, done_inval
   );

endinterface

// File: rtl/router_tx_buf.sv
// 64x8 payload store: synchronous write, combinational read on the same address.
// Zero read latency; no flow control, the FSM owns the address.
module router_tx_buf
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [BUF_AW-1:0] addr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata
);

   logic [DW-1:0] mem_q [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers a payload, then sends header/payload/parity as one burst; header 1 cycle after last load.
// Every bus byte is held while busy; done follows parity acceptance by ERR_WAIT+1 cycles.
module router_pkt_tx #(
   parameter int ERR_WAIT = 3,
   parameter int DW       = router_pkg::DW
) (
   input  logic       clk,
   input  logic       rstn,
   router_pkt_tx_if.master bus
);

   import router_pkg::*;

   localparam logic [5:0] ERR_LAST = 6'(ERR_WAIT - 1);

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [1:0]    addr_q, addr_d;
   logic [5:0]    len_q, len_d;
   logic [DW-1:0] parity_q, parity_d;
   logic          sticky_q, sticky_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          pkt_vld_q, pkt_vld_d;
   logic          req_ready_q, req_ready_d;
   logic          pay_ready_q, pay_ready_d;
   logic          tx_active_q, tx_active_d;
   logic          done_q, done_d;
   logic          done_err_q, done_err_d;
   logic          done_inval_q, done_inval_d;

   logic              buf_we;
   logic [BUF_AW-1:0] buf_addr;
   logic [DW-1:0]     buf_rdata;

   assign buf_we = (state_q == ST_LOAD) && bus.pay_valid && pay_ready_q;

   // Reads look one byte ahead so the next payload byte is ready to register on acceptance.
   always_comb begin
      buf_addr = cnt_q;
      if (state_q == ST_HEADER) begin
         buf_addr = '0;
      end else if (state_q == ST_PAYLOAD) begin
         buf_addr = cnt_q + 6'd1;
      end
   end

   router_tx_buf u_buf (
      .clk   (clk),
      .we    (buf_we),
      .addr  (buf_addr),
      .wdata (bus.pay_data),
      .rdata (buf_rdata)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      len_d        = len_q;
      parity_d     = parity_q;
      sticky_d     = sticky_q;
      data_out_d   = data_out_q;
      pkt_vld_d    = pkt_vld_q;
      done_d       = 1'b0;
      done_err_d   = 1'b0;
      done_inval_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               addr_d   = bus.req_addr;
               len_d    = bus.req_len;
               cnt_d    = '0;
               parity_d = '0;
               sticky_d = 1'b0;
               if (bus.req_addr == ADDR_INVALID) begin
                  state_d      = ST_DONE;
                  done_d       = 1'b1;
                  done_inval_d = 1'b1;
               end else if (bus.req_len == 6'd0) begin
                  state_d    = ST_HEADER;
                  data_out_d = make_hdr(bus.req_len, bus.req_addr);
                  parity_d   = make_hdr(bus.req_len, bus.req_addr);
                  pkt_vld_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (buf_we) begin
               if (cnt_q == len_q - 6'd1) begin
                  state_d    = ST_HEADER;
                  cnt_d      = '0;
                  data_out_d = make_hdr(len_q, addr_q);
                  parity_d   = make_hdr(len_q, addr_q);
                  pkt_vld_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         ST_HEADER: begin
            if (!bus.busy) begin
               if (len_q != 6'd0) begin
                  state_d    = ST_PAYLOAD;
                  data_out_d = buf_rdata;
               end else begin
                  state_d    = ST_PARITY;
                  data_out_d = parity_q;
                  pkt_vld_d  = 1'b0;
               end
            end
         end
         ST_PAYLOAD: begin
            if (!bus.busy) begin
               parity_d = parity_q ^ data_out_q;
               if (cnt_q == len_q - 6'd1) begin
                  state_d    = ST_PARITY;
                  cnt_d      = '0;
                  data_out_d = parity_q ^ data_out_q;
                  pkt_vld_d  = 1'b0;
               end else begin
                  cnt_d      = cnt_q + 6'd1;
                  data_out_d = buf_rdata;
               end
            end
         end
         ST_PARITY: begin
            if (!bus.busy) begin
               state_d    = ST_ERR_WAIT;
               cnt_d      = '0;
               data_out_d = '0;
               sticky_d   = sticky_q | bus.err;
            end
         end
         ST_ERR_WAIT: begin
            sticky_d = sticky_q | bus.err;
            if (cnt_q == ERR_LAST) begin
               state_d    = ST_DONE;
               cnt_d      = '0;
               done_d     = 1'b1;
               done_err_d = sticky_q | bus.err;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
      pay_ready_d = (state_d == ST_LOAD);
      tx_active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         parity_q     <= '0;
         sticky_q     <= 1'b0;
         data_out_q   <= '0;
         pkt_vld_q    <= 1'b0;
         req_ready_q  <= 1'b0;
         pay_ready_q  <= 1'b0;
         tx_active_q  <= 1'b0;
         done_q       <= 1'b0;
         done_err_q   <= 1'b0;
         done_inval_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         parity_q     <= parity_d;
         sticky_q     <= sticky_d;
         data_out_q   <= data_out_d;
         pkt_vld_q    <= pkt_vld_d;
         req_ready_q  <= req_ready_d;
         pay_ready_q  <= pay_ready_d;
         tx_active_q  <= tx_active_d;
         done_q       <= done_d;
         done_err_q   <= done_err_d;
         done_inval_q <= done_inval_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.pay_ready  = pay_ready_q;
   assign bus.data_out   = data_out_q;
   assign bus.pkt_vld    = pkt_vld_q;
   assign bus.tx_active  = tx_active_q;
   assign bus.done       = done_q;
   assign bus.done_err   = done_err_q;
   assign bus.done_inval = done_inval_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Drives requests, payload and router back-pressure for router_pkt_tx and checks the
// bus bytes, parity, timing and completion status against a packet-level model.
module tb_router_pkt_tx;

   localparam int ERR_WAIT = 3;

   logic clk;
   logic rstn;
   int   n_pass;
   int   n_total;

   logic [7:0] pay_plan[$];
   int         busy_plan[66];

   router_pkt_tx_if bus_if ();

   router_pkt_tx #(.ERR_WAIT(ERR_WAIT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"},  32'(bus_if.req_ready),  0);
      chk({tag, "_pay_ready"},  32'(bus_if.pay_ready),  0);
      chk({tag, "_data_out"},   32'(bus_if.data_out),   0);
      chk({tag, "_pkt_vld"},    32'(bus_if.pkt_vld),    0);
      chk({tag, "_tx_active"},  32'(bus_if.tx_active),  0);
      chk({tag, "_done"},       32'(bus_if.done),       0);
      chk({tag, "_done_err"},   32'(bus_if.done_err),   0);
      chk({tag, "_done_inval"}, 32'(bus_if.done_inval), 0);
   endtask

   task automatic plan_rand(input int len);
      pay_plan.delete();
      for (int i = 0; i < len; i++) pay_plan.push_back(8'($urandom));
      for (int i = 0; i < 66; i++) busy_plan[i] = 0;
   endtask

   // One packet: model expected bytes, drive the request/payload/busy/err, then compare.
   task automatic run_pkt(input logic [1:0] a, input int len, input bit gap,
                          input int err_at, input int abort_at);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      logic [7:0] par;
      logic [7:0] prev_dat;
      logic       prev_vld;
      int  bcnt[66];
      int  pidx, first_cyc, par_cyc, done_cyc, busy_tot, vld_after, pos, wait_n;
      bit  inval, exp_err, pv_tog, seen_vld, seen_pr, par_done, done_seen, prev_hold, act, is_par;

      inval   = (a == 2'b11);
      exp_err = (err_at >= 0) && (err_at <= ERR_WAIT);
      par     = {len[5:0], a};
      exp_q.push_back(par);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(pay_plan[i]);
         par ^= pay_plan[i];
      end
      exp_q.push_back(par);
      busy_tot = 0;
      for (int i = 0; i < 66; i++) begin
         bcnt[i]   = busy_plan[i];
         busy_tot += busy_plan[i];
      end
      pidx = 0; first_cyc = -1; par_cyc = -1; done_cyc = -1; vld_after = 0;
      pv_tog = 0; seen_vld = 0; seen_pr = 0; par_done = 0; done_seen = 0; prev_hold = 0;
      prev_dat = '0; prev_vld = 1'b0;

      @(negedge clk);
      bus_if.req_valid = 1'b1;
      bus_if.req_addr  = a;
      bus_if.req_len   = len[5:0];
      wait_n = 0;
      while (!bus_if.req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      chk("req_ready", 32'(bus_if.req_ready), 1);

      for (int cyc = 1; cyc <= 1000 && !done_seen; cyc++) begin
         @(negedge clk);
         bus_if.req_valid = 1'b0;
         if (cyc == 1) begin
            chk("tx_active_on", 32'(bus_if.tx_active), 1);
            chk("req_ready_busy", 32'(bus_if.req_ready), 0);
         end
         if (abort_at >= 0 && got_q.size() == abort_at && bus_if.pkt_vld) begin
            rstn = 1'b0;
            bus_if.pay_valid = 1'b0;
            bus_if.busy = 1'b0;
            bus_if.err = 1'b0;
            @(negedge clk);
            chk_reset("abort");
            rstn = 1'b1;
            @(negedge clk);
            return;
         end

         pv_tog = ~pv_tog;
         bus_if.pay_valid = (pidx < len) && (!gap || pv_tog);
         bus_if.pay_data  = (pidx < len) ? pay_plan[pidx] : 8'h00;
         if (bus_if.pay_ready) seen_pr = 1;
         if (bus_if.pay_ready && bus_if.pay_valid) pidx++;

         if (bus_if.pkt_vld) seen_vld = 1;
         if (par_done && bus_if.pkt_vld) vld_after++;
         pos    = got_q.size();
         is_par = seen_vld && !par_done && (pos == len + 1);
         act    = (bus_if.pkt_vld || is_par) && !par_done;
         if (act) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (prev_hold) begin
               chk("hold_dat", 32'(bus_if.data_out), 32'(prev_dat));
               chk("hold_vld", 32'(bus_if.pkt_vld), 32'(prev_vld));
            end
            bus_if.busy = (bcnt[pos] > 0);
            if (bcnt[pos] > 0) bcnt[pos]--;
            if (!bus_if.busy) begin
               got_q.push_back(bus_if.data_out);
               if (is_par) begin
                  chk("par_vld", 32'(bus_if.pkt_vld), 0);
                  par_done = 1;
                  par_cyc  = cyc;
               end
            end
            prev_hold = bus_if.busy;
            prev_dat  = bus_if.data_out;
            prev_vld  = bus_if.pkt_vld;
         end else begin
            bus_if.busy = 1'($urandom_range(0, 1));
            prev_hold = 0;
         end

         if (par_done) bus_if.err = ((cyc - par_cyc) == err_at);
         else bus_if.err = 1'($urandom_range(0, 1));

         if (bus_if.done) begin
            done_seen = 1;
            done_cyc  = cyc;
            chk("done_err",   32'(bus_if.done_err),   32'(exp_err));
            chk("done_inval", 32'(bus_if.done_inval), 32'(inval));
            chk("done_txact", 32'(bus_if.tx_active),  1);
         end
      end
      bus_if.err = 1'b0;
      bus_if.busy = 1'b0;
      bus_if.pay_valid = 1'b0;
      chk("done_seen", 32'(done_seen), 1);
      @(negedge clk);
      chk("done_pulse",   32'(bus_if.done),      0);
      chk("tx_idle",      32'(bus_if.tx_active), 0);
      chk("req_rdy_idle", 32'(bus_if.req_ready), 1);

      if (inval) begin
         chk("inv_no_vld", 32'(seen_vld), 0);
         chk("inv_no_pr",  32'(seen_pr),  0);
         chk("inv_lat",    32'(done_cyc >= 1 && done_cyc <= 2), 1);
      end else begin
         chk("bus_count", 32'(got_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("bus_byte", 32'(got_q[i]), 32'(exp_q[i]));
         end
         chk("burst_cyc", 32'(par_cyc - first_cyc + 1), 32'(len + 2 + busy_tot));
         chk("done_lat",  32'(done_cyc - par_cyc), 32'(ERR_WAIT + 1));
         chk("vld_after", 32'(vld_after), 0);
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rstn = 1'b0;
      bus_if.req_valid = 1'b0;
      bus_if.req_addr  = '0;
      bus_if.req_len   = '0;
      bus_if.pay_data  = '0;
      bus_if.pay_valid = 1'b0;
      bus_if.busy      = 1'b0;
      bus_if.err       = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rstn = 1'b1;

      // addr 1, len 4, fixed payload, no back-pressure
      plan_rand(4);
      pay_plan = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_pkt(2'd1, 4, 1'b0, -1, -1);

      // addr 2, len 3, busy on header and on the second payload byte
      plan_rand(3);
      busy_plan[0] = 2;
      busy_plan[2] = 3;
      run_pkt(2'd2, 3, 1'b0, -1, -1);

      // empty packet
      plan_rand(0);
      run_pkt(2'd0, 0, 1'b0, -1, -1);

      // invalid destination
      plan_rand(5);
      run_pkt(2'd3, 5, 1'b0, -1, -1);

      // maximum length with payload gaps
      plan_rand(63);
      run_pkt(2'd1, 63, 1'b1, -1, -1);

      // err inside the window, at its last cycle, and just after it
      plan_rand(2);
      run_pkt(2'd0, 2, 1'b0, 2, -1);
      plan_rand(2);
      run_pkt(2'd2, 2, 1'b0, 0, -1);
      plan_rand(1);
      run_pkt(2'd1, 1, 1'b0, ERR_WAIT, -1);
      plan_rand(1);
      run_pkt(2'd1, 1, 1'b0, ERR_WAIT + 1, -1);

      // reset during payload, then a clean packet afterwards
      plan_rand(10);
      run_pkt(2'd2, 10, 1'b0, -1, 3);
      plan_rand(3);
      run_pkt(2'd0, 3, 1'b0, -1, -1);

      // randomized packets with random back-pressure and err placement
      for (int k = 0; k < 8; k++) begin
         int rl;
         rl = $urandom_range(0, 20);
         plan_rand(rl);
         for (int p = 0; p < rl + 2; p++) begin
            if ($urandom_range(0, 3) == 0) busy_plan[p] = $urandom_range(1, 3);
         end
         run_pkt(2'($urandom_range(0, 2)), rl, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? int'($urandom_range(0, 5)) : -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
